// File: rtl/alram_bwclr.sv
// Single-clock 1W/1R RAM with per-byte write enables, 1- or 2-cycle read latency,
// write-first collision forwarding, and a clear engine that zeroes the array.
module alram_bwclr #(
  parameter int unsigned WID     = 256,
  parameter int unsigned AWID    = 5,
  parameter int unsigned DEP     = 1 << AWID,
  parameter int unsigned BWID    = 8,
  parameter int unsigned RLAT    = 1,
  parameter int unsigned INITCLR = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [WID/BWID-1:0]  wbe,
  input  logic [AWID-1:0]      wa,
  input  logic [WID-1:0]       wdi,
  input  logic                 re,
  input  logic [AWID-1:0]      ra,
  output logic [WID-1:0]       rdo,
  output logic                 rvld,
  input  logic                 clr,
  output logic                 busy
);

  localparam int unsigned NBE = WID / BWID;

  if ((WID % BWID) != 0) begin : g_bad_bwid
    $error("alram_bwclr: WID must be a multiple of BWID");
  end
  if ((RLAT != 1) && (RLAT != 2)) begin : g_bad_rlat
    $error("alram_bwclr: RLAT must be 1 or 2");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CLR  = 1'b1
  } state_t;

  localparam state_t RST_STATE = (INITCLR != 0) ? S_CLR : S_IDLE;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AWID-1:0] r_cnt;
  logic [AWID-1:0] w_cnt_nxt;
  logic            w_last;
  logic            w_busy;
  logic            w_wacc;
  logic            w_racc;
  logic [WID-1:0]  r_mem [DEP];
  logic [WID-1:0]  w_rword;
  logic            r_v1;
  logic [WID-1:0]  r_d1;

  assign w_busy = (r_state == S_CLR);
  assign w_last = (r_cnt == AWID'(DEP - 1));
  assign w_wacc = we & ~w_busy;
  assign w_racc = re & ~w_busy;
  assign busy   = w_busy;

  // Clear engine state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Clear engine next state: sweep every word once, clr ignored while sweeping
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (clr) w_state_nxt = S_CLR;
      end
      S_CLR: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + AWID'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Array write port; the clear owns the port while busy
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wacc) begin
      for (int i = 0; i < NBE; i++) begin
        if (wbe[i]) r_mem[wa][i*BWID +: BWID] <= wdi[i*BWID +: BWID];
      end
    end
  end

  // Same-edge write to the read address is forwarded lane by lane
  always_comb begin
    w_rword = r_mem[ra];
    if (w_wacc && (wa == ra)) begin
      for (int i = 0; i < NBE; i++) begin
        if (wbe[i]) w_rword[i*BWID +: BWID] = wdi[i*BWID +: BWID];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= w_racc;
      if (w_racc) r_d1 <= w_rword;
    end
  end

  if (RLAT == 2) begin : g_lat2
    logic           r_v2;
    logic [WID-1:0] r_d2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v2 <= 1'b0;
        r_d2 <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) r_d2 <= r_d1;
      end
    end

    assign rvld = r_v2;
    assign rdo  = r_d2;
  end else begin : g_lat1
    assign rvld = r_v1;
    assign rdo  = r_d1;
  end

endmodule

// File: tb/tb_alram_bwclr.sv
// Bench for alram_bwclr: RLAT=1 and RLAT=2 instances share one stimulus stream and
// are compared every cycle against a word-array reference model.
module tb_alram_bwclr;

  localparam int unsigned WID  = 256;
  localparam int unsigned AWID = 5;
  localparam int unsigned DEP  = 32;
  localparam int unsigned BWID = 8;
  localparam int unsigned NBE  = WID / BWID;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            we  = 1'b0;
  logic            re  = 1'b0;
  logic            clr = 1'b0;
  logic [NBE-1:0]  wbe = '0;
  logic [AWID-1:0] wa  = '0;
  logic [AWID-1:0] ra  = '0;
  logic [WID-1:0]  wdi = '0;
  logic [WID-1:0]  rdo1, rdo2;
  logic            rvld1, rvld2, busy1, busy2;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;

  logic [WID-1:0] m_mem [DEP];
  logic           m_busy;
  int             m_left;
  logic           m_v1, m_v2, m_pv;
  logic [WID-1:0] m_d1, m_d2, m_pd;
  logic [WID-1:0] exp_w, acc_or;

  always #5 clk = ~clk;

  alram_bwclr #(.WID(WID), .AWID(AWID), .DEP(DEP), .BWID(BWID), .RLAT(1), .INITCLR(1)) u_l1 (
    .clk(clk), .rst(rst), .we(we), .wbe(wbe), .wa(wa), .wdi(wdi), .re(re), .ra(ra),
    .rdo(rdo1), .rvld(rvld1), .clr(clr), .busy(busy1)
  );

  alram_bwclr #(.WID(WID), .AWID(AWID), .DEP(DEP), .BWID(BWID), .RLAT(2), .INITCLR(1)) u_l2 (
    .clk(clk), .rst(rst), .we(we), .wbe(wbe), .wa(wa), .wdi(wdi), .re(re), .ra(ra),
    .rdo(rdo2), .rvld(rvld2), .clr(clr), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [WID-1:0] obs, input logic [WID-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WID-1:0] merge(input logic [WID-1:0] old, input logic [WID-1:0] d,
                                           input logic [NBE-1:0] be);
    logic [WID-1:0] r;
    r = old;
    for (int i = 0; i < NBE; i++) if (be[i]) r[i*BWID +: BWID] = d[i*BWID +: BWID];
    return r;
  endfunction

  function automatic logic [WID-1:0] rand_word();
    logic [WID-1:0] r;
    for (int i = 0; i < WID / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 1'b1;
    m_left = DEP;
    m_v1 = 1'b0; m_v2 = 1'b0; m_pv = 1'b0;
    m_d1 = '0;   m_d2 = '0;   m_pd = '0;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; clr = 1'b0; wbe = '0;
  endtask

  // Predict the effect of the coming edge, take it, then compare both instances
  task automatic step();
    logic           acc;
    logic [WID-1:0] d;
    if (rst) begin
      model_reset();
    end else begin
      if (busy1 === 1'b1) busy_cnt++;
      acc = 1'b0;
      d   = '0;
      if (m_busy) begin
        m_mem[DEP - m_left] = '0;
        m_left--;
        if (m_left == 0) m_busy = 1'b0;
      end else begin
        if (we) m_mem[wa] = merge(m_mem[wa], wdi, wbe);
        if (re) begin
          acc = 1'b1;
          d   = m_mem[ra];
        end
        if (clr) begin
          m_busy = 1'b1;
          m_left = DEP;
        end
      end
      m_v1 = acc;
      if (acc) m_d1 = d;
      m_v2 = m_pv;
      if (m_pv) m_d2 = m_pd;
      m_pv = acc;
      m_pd = d;
    end
    @(posedge clk);
    #1;
    chk("busy_l1", WID'(busy1), WID'(m_busy));
    chk("busy_l2", WID'(busy2), WID'(m_busy));
    chk("rvld_l1", WID'(rvld1), WID'(m_v1));
    chk("rvld_l2", WID'(rvld2), WID'(m_v2));
    chk("rdo_l1", rdo1, m_d1);
    chk("rdo_l2", rdo2, m_d2);
  endtask

  task automatic read_all_zero(input string tag);
    acc_or = '0;
    for (int a = 0; a < DEP; a++) begin
      idle(); re = 1'b1; ra = AWID'(a);
      step();
      if (rvld1 === 1'b1) acc_or = acc_or | rdo1;
    end
    idle(); step();
    if (rvld2 === 1'b1) acc_or = acc_or | rdo2;
    step();
    chk(tag, acc_or, '0);
  endtask

  task automatic wait_not_busy();
    for (int n = 0; n < 2 * DEP && m_busy; n++) step();
    chk("clear_done_bound", WID'(m_busy), '0);
  endtask

  initial begin
    for (int a = 0; a < DEP; a++) m_mem[a] = 'x;
    model_reset();
    idle();

    // Reset state, then the automatic clear after release
    repeat (3) step();
    rst = 1'b0;
    busy_cnt = 0;
    repeat (DEP + 3) step();
    chk("init_clear_width", WID'(busy_cnt), WID'(DEP));
    read_all_zero("init_all_zero");

    // Partial-lane write
    idle(); we = 1'b1; wa = 5'd3; wdi = {NBE{8'hAA}}; wbe = '1; step();
    idle(); we = 1'b1; wa = 5'd3; wdi = {NBE{8'h55}}; wbe = NBE'(1); step();
    idle(); re = 1'b1; ra = 5'd3; step();
    idle(); step();
    exp_w = {NBE{8'hAA}};
    exp_w[7:0] = 8'h55;
    chk("lane0_merge_l1", rdo1, exp_w);
    chk("lane0_merge_l2", rdo2, exp_w);

    // Same-edge collision, full and single-lane
    idle(); we = 1'b1; wa = 5'd7; wdi = {NBE{8'h11}}; wbe = '1; step();
    idle(); we = 1'b1; wa = 5'd7; wdi = {NBE{8'h22}}; wbe = '1; re = 1'b1; ra = 5'd7; step();
    idle(); step();
    chk("collide_full_l2", rdo2, {NBE{8'h22}});
    idle(); we = 1'b1; wa = 5'd7; wdi = {NBE{8'h11}}; wbe = '1; step();
    idle(); we = 1'b1; wa = 5'd7; wdi = {NBE{8'h22}}; wbe = NBE'(2); re = 1'b1; ra = 5'd7; step();
    idle(); step();
    exp_w = {NBE{8'h11}};
    exp_w[15:8] = 8'h22;
    chk("collide_lane1_l1", rdo1, exp_w);
    chk("collide_lane1_l2", rdo2, exp_w);

    // Fill with distinct data, stream reads back-to-back
    for (int a = 0; a < DEP; a++) begin
      idle(); we = 1'b1; wa = AWID'(a); wdi = rand_word(); wbe = '1; step();
    end
    for (int a = 0; a < DEP; a++) begin
      idle(); re = 1'b1; ra = AWID'(a); step();
    end
    idle(); repeat (3) step();

    // Clear while streaming traffic, second clr mid-clear ignored
    busy_cnt = 0;
    for (int c = 0; c < DEP + 3; c++) begin
      we = 1'b1; re = 1'b1; wa = AWID'($urandom); ra = AWID'($urandom);
      wdi = rand_word(); wbe = NBE'($urandom);
      clr = (c == 2) || (c == 15);
      step();
    end
    chk("clr_stream_width", WID'(busy_cnt), WID'(DEP));
    read_all_zero("clr_all_zero");

    // Random mixed traffic with occasional clears
    for (int c = 0; c < 400; c++) begin
      we = 1'($urandom); re = 1'($urandom);
      wa = AWID'($urandom); ra = AWID'($urandom);
      wdi = rand_word(); wbe = NBE'($urandom);
      if ((c % 5) == 0) wa = ra;
      clr = ($urandom_range(0, 99) == 0);
      step();
    end
    idle();
    wait_not_busy();

    // Asynchronous reset in the middle of a clear
    idle(); we = 1'b1; wa = 5'd5; wdi = {NBE{8'h5A}}; wbe = '1; step();
    idle(); re = 1'b1; ra = 5'd5; step();
    idle(); step();
    idle(); clr = 1'b1; step();
    idle(); repeat (10) step();
    #3 rst = 1'b1;
    #1;
    chk("arst_rdo_l1", rdo1, '0);
    chk("arst_rdo_l2", rdo2, '0);
    chk("arst_rvld_l1", WID'(rvld1), '0);
    chk("arst_busy_l1", WID'(busy1), WID'(1'b1));
    chk("arst_busy_l2", WID'(busy2), WID'(1'b1));
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    busy_cnt = 0;
    repeat (DEP + 2) step();
    chk("arst_clear_width", WID'(busy_cnt), WID'(DEP));
    read_all_zero("arst_all_zero");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
